// File: rtl/alu_pkg.sv
// Shared constants, result record and MISR step for the ALU result buffer.
// The MISR helper is only referenced when ALU_RESULT_SIGNATURE_EN is defined.
package alu_pkg;

   localparam int ALU_W    = 16;
   localparam int FLAG_W   = 4;
   localparam int RESULT_W = ALU_W + FLAG_W;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [ALU_W-1:0] MISR_POLY = 16'h1021;
   localparam logic [ALU_W-1:0] MISR_SEED = 16'hFFFF;

   typedef struct packed {
      logic [FLAG_W-1:0] flags;
      logic [ALU_W-1:0]  data;
   } result_t;

   function automatic logic [ALU_W-1:0] misr_next(input logic [ALU_W-1:0]  sig,
                                                  input logic [ALU_W-1:0]  data,
                                                  input logic [FLAG_W-1:0] flags);
      logic [ALU_W-1:0] sh;
      sh = {sig[ALU_W-2:0], 1'b0} ^ (sig[ALU_W-1] ? MISR_POLY : '0);
      return sh ^ data ^ {{(ALU_W-FLAG_W){1'b0}}, flags};
   endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers and occupancy count.
// Head word reads as zero while empty; clr empties the FIFO with top priority.
module sync_fifo_core #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   output logic                     rd_valid,
   output logic [WIDTH-1:0]         rd_data,
   input  logic                     rd_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   // Handshake flags come only from the registered count, so in_ready never sees out_ready.
   assign wr_ready = (count_q != CNT_FULL);
   assign rd_valid = (count_q != '0);
   assign push     = wr_valid & wr_ready & ~clr;
   assign pop      = rd_valid & rd_ready & ~clr;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count   = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: FIFO of {flags,data}, saturating drop counter, sticky overflow.
// Define ALU_RESULT_SIGNATURE_EN to build the 16-bit MISR over accepted results.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic [ALU_W-1:0]         in_data,
   input  logic [FLAG_W-1:0]        in_flags,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [ALU_W-1:0]         out_data,
   output logic [FLAG_W-1:0]        out_flags,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic [DROP_W-1:0]        drop_cnt,
   output logic                     overflow,
   output logic [ALU_W-1:0]         signature
);

   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

   result_t          in_res, out_res;
   logic             drop;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic             overflow_q, overflow_d;

   assign in_res = '{flags: in_flags, data: in_data};

   sync_fifo_core #(
      .WIDTH (RESULT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .wr_valid (in_valid),
      .wr_data  (in_res),
      .wr_ready (in_ready),
      .rd_valid (out_valid),
      .rd_data  (out_res),
      .rd_ready (out_ready),
      .count    (count)
   );

   assign out_data  = out_res.data;
   assign out_flags = out_res.flags;
   assign drop      = in_valid & ~in_ready;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      overflow_d = overflow_q;
      if (clr) begin
         drop_cnt_d = '0;
         overflow_d = 1'b0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign overflow = overflow_q;

`ifdef ALU_RESULT_SIGNATURE_EN
   logic             push;
   logic [ALU_W-1:0] sig_q, sig_d;

   assign push = in_valid & in_ready & ~clr;

   always_comb begin
      sig_d = sig_q;
      if (clr)       sig_d = MISR_SEED;
      else if (push) sig_d = misr_next(sig_q, in_data, in_flags);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= MISR_SEED;
      else        sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   assign signature = '0;
`endif

endmodule
